dino_game_sequencer: RTL

Top-level game-phase controller for the Dino Run VGA datapath. It owns the run/hit/game-over/replay sequence and generates the motion tick that advances obstacles. It also owns obstacle speed level, the BCD score and the high score. The obstacle/collision/drawing datapath consumes its strobes and levels and no longer keeps its own timers, score or game_over flag.

---
 rtl/dino_game_sequencer_if.sv | 29 ++
 rtl/dino_game_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dino_game_sequencer_if.sv
// Control/status bundle between the game sequencer and the obstacle/draw datapath.
// The master side is the sequencer; the slave side is the datapath that consumes its strobes.
interface dino_game_sequencer_if;
    logic        start_btn;
    logic        collision;
    logic        obstacle_passed;
    logic        frame_start;
    logic [2:0]  phase;
    logic        run_en;
    logic        world_reset;
    logic        motion_tick;
    logic        anim_tick;
    logic [3:0]  speed;
    logic [11:0] score_bcd;
    logic [11:0] hi_score_bcd;
    logic        show_replay;

    modport master (
        input  start_btn, collision, obstacle_passed, frame_start,
        output phase, run_en, world_reset, motion_tick, anim_tick,
               speed, score_bcd, hi_score_bcd, show_replay
    );

    modport slave (
        output start_btn, collision, obstacle_passed, frame_start,
        input  phase, run_en, world_reset, motion_tick, anim_tick,
               speed, score_bcd, hi_score_bcd, show_replay
    );
endinterface

// File: rtl/dino_game_sequencer.sv
// Game-phase controller: run/hit/over/replay sequencing, motion and anim ticks, speed, BCD score and high score.
// All outputs registered; start button sees 3 cycles of sync/edge latency, other inputs act one cycle after sampling.
module dino_game_sequencer #(
    parameter int TICK_CYCLES    = 2_000_000,
    parameter int PASS_PER_LEVEL = 12,
    parameter int MAX_SPEED      = 8,
    parameter int HIT_FRAMES     = 30,
    parameter int ANIM_DIV       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dino_game_sequencer_if.master  bus
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int PW = $clog2(PASS_PER_LEVEL + 1);
    localparam int FW = $clog2(HIT_FRAMES + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
    localparam logic [PW-1:0] PASS_LAST  = PW'(PASS_PER_LEVEL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(HIT_FRAMES - 1);
    localparam logic [3:0]    SPEED_MAX  = 4'(MAX_SPEED);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESTART = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_HIT     = 3'd3;
    localparam logic [2:0] ST_OVER    = 3'd4;

    logic          sync1_q, sync2_q, sync3_q;
    logic          start_rise;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [AW-1:0] anim_cnt_q, anim_cnt_d;
    logic [PW-1:0] pass_cnt_q, pass_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]    speed_q, speed_d;
    logic [11:0]   score_q, score_d;
    logic [11:0]   hi_score_q, hi_score_d;
    logic          run_en_q, run_en_d;
    logic          world_reset_q, world_reset_d;
    logic          motion_tick_q, motion_tick_d;
    logic          anim_tick_q, anim_tick_d;
    logic          show_replay_q, show_replay_d;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    assign start_rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        anim_cnt_d    = anim_cnt_q;
        pass_cnt_d    = pass_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        speed_d       = speed_q;
        score_d       = score_q;
        hi_score_d    = hi_score_q;
        world_reset_d = 1'b0;
        motion_tick_d = 1'b0;
        anim_tick_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_RESTART;
            end
            ST_RESTART: state_d = ST_RUN;
            ST_RUN: begin
                // A collision freezes the world in the very cycle it is seen.
                if (bus.collision) begin
                    state_d     = ST_HIT;
                    frame_cnt_d = '0;
                end else begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d    = '0;
                        motion_tick_d = 1'b1;
                        score_d       = bcd_inc(score_q);
                        if (anim_cnt_q == ANIM_LAST) begin
                            anim_cnt_d  = '0;
                            anim_tick_d = 1'b1;
                        end else begin
                            anim_cnt_d = anim_cnt_q + AW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                    if (bus.obstacle_passed) begin
                        if (pass_cnt_q == PASS_LAST) begin
                            pass_cnt_d = '0;
                            if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
                        end else begin
                            pass_cnt_d = pass_cnt_q + PW'(1);
                        end
                    end
                end
            end
            ST_HIT: begin
                if (bus.frame_start) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = ST_OVER;
                        if (score_q > hi_score_q) hi_score_d = score_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) state_d = ST_RESTART;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clearing on entry makes the restart cycle already show the fresh game.
        if (state_d == ST_RESTART) begin
            world_reset_d = 1'b1;
            score_d       = '0;
            speed_d       = 4'd1;
            pass_cnt_d    = '0;
            tick_cnt_d    = '0;
            anim_cnt_d    = '0;
        end

        run_en_d      = (state_d == ST_RUN);
        show_replay_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            state_q       <= ST_IDLE;
            tick_cnt_q    <= '0;
            anim_cnt_q    <= '0;
            pass_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            speed_q       <= 4'd1;
            score_q       <= '0;
            hi_score_q    <= '0;
            run_en_q      <= 1'b0;
            world_reset_q <= 1'b0;
            motion_tick_q <= 1'b0;
            anim_tick_q   <= 1'b0;
            show_replay_q <= 1'b0;
        end else begin
            sync1_q       <= bus.start_btn;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            anim_cnt_q    <= anim_cnt_d;
            pass_cnt_q    <= pass_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            speed_q       <= speed_d;
            score_q       <= score_d;
            hi_score_q    <= hi_score_d;
            run_en_q      <= run_en_d;
            world_reset_q <= world_reset_d;
            motion_tick_q <= motion_tick_d;
            anim_tick_q   <= anim_tick_d;
            show_replay_q <= show_replay_d;
        end
    end

    assign bus.phase        = state_q;
    assign bus.run_en       = run_en_q;
    assign bus.world_reset  = world_reset_q;
    assign bus.motion_tick  = motion_tick_q;
    assign bus.anim_tick    = anim_tick_q;
    assign bus.speed        = speed_q;
    assign bus.score_bcd    = score_q;
    assign bus.hi_score_bcd = hi_score_q;
    assign bus.show_replay  = show_replay_q;
endmodule
